str_pack: RTL
=============

Name: str_pack

Overview:
Stream packer. Accepts a narrow valid/ready/last stream and emits a wide valid/ready/last stream of DATA_NB narrow beats per word, first beat in the least significant lane. It is the wide-side counterpart of the downsizing gearbox: words it produces unpack back to the original beat order. On up_last it flushes a partial word early and marks the occupied lanes on dn_keep, so packet boundaries survive the width change.

Parameters:
DATA_UP_WIDTH, 8, width of one input beat (one lane)
DATA_DN_WIDTH, 24, output word width; must be an integer multiple of DATA_UP_WIDTH, with a ratio of at least 2
DATA_NB, DATA_DN_WIDTH/DATA_UP_WIDTH, lanes per output word (derived localparam, not overridable)

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  reset, asynchronous assert, active-low (0 = reset)
up_data  input  DATA_UP_WIDTH  input beat
up_last  input  1  final beat of a packet; qualified by up_val
up_val  input  1  input beat valid
up_rdy  output  1  input beat accepted when up_val & up_rdy
dn_data  output  DATA_DN_WIDTH  packed word; lane k = bits [k*DATA_UP_WIDTH +: DATA_UP_WIDTH]
dn_keep  output  DATA_NB  lane occupancy; bit k set = lane k holds data
dn_last  output  1  word contains the packet's final beat
dn_val  output  1  output word valid
dn_rdy  input  1  downstream accepts the word when dn_val & dn_rdy

Behaviour:
- Reset while rst=0: dn_val=0, dn_last=0, dn_keep=0, dn_data=0, lane index idx=0, accumulator cleared, up_rdy=0. Reset mid-packet discards the partial word and the held output word.
- up_rdy = rst & (~dn_val | dn_rdy). It is combinational from dn_rdy and does not depend on up_val or up_last.
- Input transfer, when up_val & up_rdy:
  - up_data is written to accumulator lane idx.
  - If idx == DATA_NB-1 or up_last=1, the word completes.
  - Otherwise idx increments.
- On word completion, the output register loads on the same clock edge:
  - dn_data = accumulator lanes 0..idx-1 merged with up_data in lane idx; lanes above idx are zero.
  - dn_keep = bits 0..idx set (e.g. idx=1 gives 3'b011).
  - dn_last = up_last.
  - dn_val = 1.
  - idx returns to 0 and the accumulator is cleared.
- Latency: the word is visible on dn_* one cycle after the edge that accepted its completing beat.
- Output transfer, when dn_val & dn_rdy: dn_val falls on the next edge unless a new word completes on the same edge, in which case the register reloads and dn_val stays 1.
- While dn_val=1 and dn_rdy=0: dn_data, dn_keep and dn_last are held stable, and up_rdy=0, so accumulation also stalls.
- Throughput: one beat per cycle and no bubbles while dn_rdy is held at 1.
- Words without up_last always have dn_keep all ones. dn_last=1 only together with dn_val=1.
- up_last on lane 0 gives a single-lane word (dn_keep = ...001, upper lanes 0).
- Back-to-back packets: the beat after a last beat always goes to lane 0.
- up_last is ignored unless up_val & up_rdy.
- idx never exceeds DATA_NB-1.

Test Plan:
All scenarios use DATA_UP_WIDTH=8, DATA_DN_WIDTH=24. The input stream is 0x01, 0x02, 0x03, … with up_val=1 throughout.

1. Reset: hold rst=0 for 6 cycles with up_val=1 -> up_rdy=0, dn_val=0, dn_data=0, dn_keep=0 throughout. Release rst -> up_rdy=1 on the first cycle.
2. Continuous dn_rdy=1 for 20 cycles -> dn_data sequence 0x030201, 0x060504, 0x090807, …; dn_keep=3'b111 and dn_last=0 on every word; up_rdy=1 every cycle; first dn_val one cycle after beat 0x03 is accepted.
3. Backpressure: dn_rdy=0 for 10 cycles while word 0x060504 is valid -> dn_data, dn_keep and dn_last held; up_rdy=0 and no beats consumed. Restore dn_rdy=1 -> next word is 0x090807, with no lost or duplicated beat.
4. Partial flush: up_last=1 on beat 0x05 following 0x04 -> dn_data=0x000504, dn_keep=3'b011, dn_last=1. Next word starts in lane 0 with 0x06.
5. Single-beat packet: up_last=1 on the beat right after a completed word (value 0x07) -> dn_data=0x000007, dn_keep=3'b001, dn_last=1. With up_last=1 on lane 2 instead -> dn_keep=3'b111, dn_last=1.
6. Reset mid-packet: take rst low after beats 0x01 and 0x02 are accepted, release it, then send 0x0A, 0x0B, 0x0C -> first word is 0x0C0B0A; no remnant of 0x01 or 0x02 appears.

Source files
------------

// File: rtl/str_pack_if.sv
// Narrow input stream and wide output stream of the packer, bundled as one port.
// slave is the packer's view; master is the view of the logic driving it.
interface str_pack_if #(
    parameter int DATA_UP_WIDTH = 8,
    parameter int DATA_DN_WIDTH = 24
);
    localparam int DATA_NB = DATA_DN_WIDTH / DATA_UP_WIDTH;

    logic [DATA_UP_WIDTH-1:0] up_data;
    logic                     up_last;
    logic                     up_val;
    logic                     up_rdy;
    logic [DATA_DN_WIDTH-1:0] dn_data;
    logic [DATA_NB-1:0]       dn_keep;
    logic                     dn_last;
    logic                     dn_val;
    logic                     dn_rdy;

    modport master (
        output up_data, up_last, up_val,
        input  up_rdy,
        input  dn_data, dn_keep, dn_last, dn_val,
        output dn_rdy
    );

    modport slave (
        input  up_data, up_last, up_val,
        output up_rdy,
        output dn_data, dn_keep, dn_last, dn_val,
        input  dn_rdy
    );
endinterface

// File: rtl/str_pack.sv
// Stream packer: gathers DATA_NB narrow beats into one wide word, lane 0 first.
// up_last flushes a partial word early and dn_keep marks the occupied lanes.
module str_pack #(
    parameter int DATA_UP_WIDTH = 8,
    parameter int DATA_DN_WIDTH = 24
) (
    input  logic      clk,
    input  logic      rst,
    str_pack_if.slave bus
);
    localparam int DATA_NB = DATA_DN_WIDTH / DATA_UP_WIDTH;
    localparam int IDX_W   = (DATA_NB > 1) ? $clog2(DATA_NB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_NB - 1);

    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [DATA_DN_WIDTH-1:0] acc_q, acc_d;
    logic [DATA_DN_WIDTH-1:0] dn_data_q, dn_data_d;
    logic [DATA_NB-1:0]       dn_keep_q, dn_keep_d;
    logic                     dn_last_q, dn_last_d;
    logic                     dn_val_q, dn_val_d;

    logic [DATA_DN_WIDTH-1:0] merged;
    logic [DATA_NB-1:0]       keep_mask;
    logic                     up_rdy;
    logic                     take;
    logic                     done;

    // A held word blocks the input; freeing it and loading the next share one edge.
    assign up_rdy = rst & (~dn_val_q | bus.dn_rdy);
    assign take   = bus.up_val & up_rdy;
    assign done   = take & ((idx_q == LAST_IDX) | bus.up_last);

    // Lanes above idx are always zero in the accumulator, so the merge needs no masking.
    always_comb begin
        merged    = acc_q;
        keep_mask = '0;
        for (int k = 0; k < DATA_NB; k++) begin
            if (idx_q == IDX_W'(k)) begin
                merged[k*DATA_UP_WIDTH +: DATA_UP_WIDTH] = bus.up_data;
            end
            keep_mask[k] = (IDX_W'(k) <= idx_q);
        end
    end

    always_comb begin
        idx_d     = idx_q;
        acc_d     = acc_q;
        dn_data_d = dn_data_q;
        dn_keep_d = dn_keep_q;
        dn_last_d = dn_last_q;
        dn_val_d  = dn_val_q;

        if (dn_val_q && bus.dn_rdy) begin
            dn_val_d  = 1'b0;
            dn_last_d = 1'b0;
        end

        if (take) begin
            if (done) begin
                dn_data_d = merged;
                dn_keep_d = keep_mask;
                dn_last_d = bus.up_last;
                dn_val_d  = 1'b1;
                idx_d     = '0;
                acc_d     = '0;
            end else begin
                acc_d = merged;
                idx_d = idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q     <= '0;
            acc_q     <= '0;
            dn_data_q <= '0;
            dn_keep_q <= '0;
            dn_last_q <= 1'b0;
            dn_val_q  <= 1'b0;
        end else begin
            idx_q     <= idx_d;
            acc_q     <= acc_d;
            dn_data_q <= dn_data_d;
            dn_keep_q <= dn_keep_d;
            dn_last_q <= dn_last_d;
            dn_val_q  <= dn_val_d;
        end
    end

    assign bus.up_rdy  = up_rdy;
    assign bus.dn_data = dn_data_q;
    assign bus.dn_keep = dn_keep_q;
    assign bus.dn_last = dn_last_q;
    assign bus.dn_val  = dn_val_q;
endmodule
